// File: rtl/lsc_i2c_defs.sv
// Shared definitions for the 16-bit-offset I2C target and its initiator bench:
// FSM encodings, bus widths and the ACK/NACK line levels.
package lsc_i2c_defs;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_DEV    = 4'd1,
      ST_DACK   = 4'd2,
      ST_AHI    = 4'd3,
      ST_AKH    = 4'd4,
      ST_ALO    = 4'd5,
      ST_AKL    = 4'd6,
      ST_WR     = 4'd7,
      ST_WACK   = 4'd8,
      ST_RD     = 4'd9,
      ST_MACK   = 4'd10,
      ST_IGNORE = 4'd11
   } i2cs_state_e;

   // Register offset increment; wraps 16'hFFFF -> 0.
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/lsc_i2c_sync.sv
// Two-flop synchronizer for an asynchronous pad input with registered
// level and single-cycle rise/fall pulses (3 clk pad-to-pulse).
module lsc_i2c_sync (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic meta;
   logic lvl_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta  <= 1'b1;
         lvl   <= 1'b1;
         lvl_q <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         meta  <= d;
         lvl   <= meta;
         lvl_q <= lvl;
         rise  <= lvl & ~lvl_q;
         fall  <= ~lvl & lvl_q;
      end
   end

endmodule

// File: rtl/lsc_i2cs_16.sv
// I2C target with 16-bit register offset and 8-bit data, bridging bus
// transactions onto a single-cycle register-file strobe interface.
module lsc_i2cs_16
   import lsc_i2c_defs::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h24
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_out,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   lsc_i2c_sync u_scl_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (scl_in),
      .lvl    (scl_lvl),
      .rise   (scl_rise),
      .fall   (scl_fall)
   );

   lsc_i2c_sync u_sda_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (sda_in),
      .lvl    (sda_lvl),
      .rise   (sda_rise),
      .fall   (sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   i2cs_state_e          state, state_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [DATA_W-1:0]    shreg, shreg_nxt;
   logic [DATA_W-1:0]    shift_in;
   logic                 ack_on, ack_on_nxt;
   logic                 rd_ld, rd_ld_nxt;
   logic                 sda_out_nxt;
   logic [ADDR_W-1:0]    addr_nxt;
   logic [DATA_W-1:0]    wdata_nxt;
   logic                 wr_nxt, rd_nxt, busy_nxt;
   logic                 last_bit;

   assign shift_in = {shreg[DATA_W-2:0], sda_lvl};
   assign last_bit = (bit_cnt == BIT_CNT_W'(DATA_W - 1));

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         ack_on    <= 1'b0;
         rd_ld     <= 1'b0;
         sda_out   <= 1'b1;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         ack_on    <= ack_on_nxt;
         rd_ld     <= rd_ld_nxt;
         sda_out   <= sda_out_nxt;
         reg_addr  <= addr_nxt;
         reg_wdata <= wdata_nxt;
         reg_wr    <= wr_nxt;
         reg_rd    <= rd_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next-state and output logic. ack_on marks the second half of an ACK slot
   // (target driving) or, in MACK, that the master acknowledged.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      ack_on_nxt  = ack_on;
      rd_ld_nxt   = reg_rd;
      sda_out_nxt = sda_out;
      addr_nxt    = reg_addr;
      wdata_nxt   = reg_wdata;
      wr_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      busy_nxt    = busy;

      if (reg_wr) begin
         addr_nxt = addr_inc(reg_addr);
      end

      if (!enable) begin
         state_nxt   = ST_IDLE;
         sda_out_nxt = 1'b1;
         ack_on_nxt  = 1'b0;
         rd_ld_nxt   = 1'b0;
         busy_nxt    = 1'b0;
      end else if (stop_det) begin
         state_nxt   = ST_IDLE;
         sda_out_nxt = 1'b1;
         ack_on_nxt  = 1'b0;
         rd_ld_nxt   = 1'b0;
         busy_nxt    = 1'b0;
      end else if (start_det) begin
         state_nxt   = ST_DEV;
         bit_cnt_nxt = '0;
         sda_out_nxt = 1'b1;
         ack_on_nxt  = 1'b0;
         rd_ld_nxt   = 1'b0;
      end else begin
         case (state)
            ST_DEV: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  if (last_bit) begin
                     if (shift_in[DATA_W-1:1] == DEV_ADDR) begin
                        state_nxt = ST_DACK;
                        busy_nxt  = 1'b1;
                     end else begin
                        state_nxt = ST_IGNORE;
                        busy_nxt  = 1'b0;
                     end
                  end
               end
            end

            ST_AHI, ST_ALO, ST_WR: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  if (last_bit) begin
                     case (state)
                        ST_AHI: begin
                           state_nxt                 = ST_AKH;
                           addr_nxt[ADDR_W-1:DATA_W] = shift_in;
                        end
                        ST_ALO: begin
                           state_nxt            = ST_AKL;
                           addr_nxt[DATA_W-1:0] = shift_in;
                        end
                        default: begin
                           state_nxt = ST_WACK;
                           wdata_nxt = shift_in;
                           wr_nxt    = 1'b1;
                        end
                     endcase
                  end
               end
            end

            // First SCL fall drives the ACK, the next one ends the slot.
            ST_DACK, ST_AKH, ST_AKL, ST_WACK: begin
               if (scl_fall) begin
                  if (!ack_on) begin
                     sda_out_nxt = ACK;
                     ack_on_nxt  = 1'b1;
                  end else begin
                     sda_out_nxt = 1'b1;
                     ack_on_nxt  = 1'b0;
                     bit_cnt_nxt = '0;
                     case (state)
                        ST_DACK: begin
                           if (shreg[0]) begin
                              state_nxt = ST_RD;
                              rd_nxt    = 1'b1;
                           end else begin
                              state_nxt = ST_AHI;
                           end
                        end
                        ST_AKH:  state_nxt = ST_ALO;
                        default: state_nxt = ST_WR;
                     endcase
                  end
               end
            end

            // rd_ld follows reg_rd by one cycle, when reg_rdata is valid.
            ST_RD: begin
               if (rd_ld) begin
                  shreg_nxt   = reg_rdata;
                  sda_out_nxt = reg_rdata[DATA_W-1];
               end else if (scl_fall) begin
                  if (last_bit) begin
                     state_nxt   = ST_MACK;
                     sda_out_nxt = 1'b1;
                     bit_cnt_nxt = '0;
                  end else begin
                     shreg_nxt   = {shreg[DATA_W-2:0], 1'b1};
                     sda_out_nxt = shreg[DATA_W-2];
                     bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end

            ST_MACK: begin
               if (scl_rise && !ack_on) begin
                  addr_nxt = addr_inc(reg_addr);
                  if (sda_lvl == ACK) begin
                     ack_on_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_IGNORE;
                  end
               end else if (scl_fall && ack_on) begin
                  ack_on_nxt  = 1'b0;
                  rd_nxt      = 1'b1;
                  bit_cnt_nxt = '0;
                  state_nxt   = ST_RD;
               end
            end

            ST_IDLE, ST_IGNORE: begin
               sda_out_nxt = 1'b1;
            end

            default: begin
               state_nxt   = ST_IDLE;
               sda_out_nxt = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsc_i2cs_16.sv
// Bench for lsc_i2cs_16: a bit-level I2C master, a register-file responder and
// a transaction-level reference model of expected strobes, ACKs and read data.
module tb_lsc_i2cs_16;
   import lsc_i2c_defs::*;

   localparam int unsigned H   = 10;
   localparam logic [6:0]  DEV = 7'h24;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b1;
   logic        m_scl  = 1'b1;
   logic        m_sda  = 1'b1;
   logic        sda_in;
   logic        sda_out;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_rdata = 8'h00;
   logic        busy;

   assign sda_in = m_sda & sda_out;

   always #5 clk = ~clk;

   lsc_i2cs_16 #(.DEV_ADDR(DEV)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .scl_in    (m_scl),
      .sda_in    (sda_in),
      .sda_out   (sda_out),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   function automatic logic [7:0] rf_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h7C;
   endfunction

   // Register file: data only valid on the cycle after a read request.
   always @(posedge clk)
      reg_rdata <= reg_rd ? rf_val(reg_addr) : 8'($urandom);

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         wr_log[$];
   logic [15:0] rd_log[$];
   int          both_hi = 0;
   int          busy_hi = 0;
   int          drv_lo  = 0;

   always @(negedge clk) begin
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_log.push_back(reg_addr);
      if (reg_wr && reg_rd) both_hi++;
      if (busy) busy_hi++;
      if (!sda_out) drv_lo++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_w(input logic b);
      wclk(2); m_sda = b; wclk(H - 2); m_scl = 1'b1; wclk(H); m_scl = 1'b0;
   endtask

   task automatic bit_r(output logic b);
      wclk(2); m_sda = 1'b1; wclk(H - 2); m_scl = 1'b1; wclk(H / 2);
      b = sda_in; wclk(H / 2); m_scl = 1'b0;
   endtask

   task automatic i2c_start;
      if (!m_scl) begin
         wclk(2); m_sda = 1'b1; wclk(H - 2); m_scl = 1'b1; wclk(H);
      end
      m_sda = 1'b0; wclk(H); m_scl = 1'b0;
   endtask

   task automatic i2c_stop;
      wclk(2); m_sda = 1'b0; wclk(H - 2); m_scl = 1'b1; wclk(H); m_sda = 1'b1; wclk(H);
   endtask

   task automatic byte_w(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(ack);
   endtask

   task automatic byte_r(output logic [7:0] d, input logic last);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bit_r(b);
         d = {d[6:0], b};
      end
      bit_w(last);
   endtask

   logic [15:0] exp_ptr = 16'h0000;
   logic [7:0]  wbuf[0:7];

   task automatic addr_phase(input logic [15:0] off);
      logic a;
      i2c_start;
      byte_w({DEV, 1'b0}, a);   chk("dev_ack", a, ACK);
      chk("busy_on", busy, 1'b1);
      byte_w(off[15:8], a);     chk("ahi_ack", a, ACK);
      byte_w(off[7:0], a);      chk("alo_ack", a, ACK);
   endtask

   task automatic do_write(input logic [15:0] off, input int n);
      logic        a;
      logic [15:0] ea;
      wr_log.delete();
      rd_log.delete();
      addr_phase(off);
      for (int i = 0; i < n; i++) begin
         byte_w(wbuf[i], a);
         chk("data_ack", a, ACK);
      end
      i2c_stop;
      wclk(H);
      chk("wr_cnt", wr_log.size(), n);
      chk("rd_cnt_w", rd_log.size(), 0);
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
         ea = off + 16'(i);
         chk("wr_addr", wr_log[i].a, ea);
         chk("wr_data", wr_log[i].d, wbuf[i]);
      end
      exp_ptr = off + 16'(n);
      chk("addr_after_wr", reg_addr, exp_ptr);
      chk("busy_off", busy, 1'b0);
   endtask

   task automatic do_read(input logic [15:0] off, input int n);
      logic        a;
      logic [7:0]  d;
      logic [15:0] ea;
      wr_log.delete();
      rd_log.delete();
      addr_phase(off);
      i2c_start;
      byte_w({DEV, 1'b1}, a);
      chk("rdev_ack", a, ACK);
      for (int i = 0; i < n; i++) begin
         byte_r(d, (i == n - 1) ? NACK : ACK);
         ea = off + 16'(i);
         chk("rd_data", d, rf_val(ea));
      end
      i2c_stop;
      wclk(H);
      chk("rd_cnt", rd_log.size(), n);
      chk("wr_cnt_r", wr_log.size(), 0);
      for (int i = 0; i < n && i < rd_log.size(); i++) begin
         ea = off + 16'(i);
         chk("rd_addr", rd_log[i], ea);
      end
      exp_ptr = off + 16'(n);
      chk("addr_after_rd", reg_addr, exp_ptr);
      chk("busy_off_r", busy, 1'b0);
   endtask

   task automatic do_mismatch(input logic [6:0] dev, input logic rw);
      logic a;
      wr_log.delete();
      rd_log.delete();
      busy_hi = 0;
      drv_lo  = 0;
      i2c_start;
      byte_w({dev, rw}, a);       chk("mis_dev_nack", a, NACK);
      byte_w(8'($urandom), a);    chk("mis_byte_nack", a, NACK);
      i2c_stop;
      wclk(H);
      chk("mis_busy", busy_hi, 0);
      chk("mis_drive", drv_lo, 0);
      chk("mis_strobes", wr_log.size() + rd_log.size(), 0);
      chk("mis_addr", reg_addr, exp_ptr);
   endtask

   task automatic do_abort(input logic [15:0] off);
      wr_log.delete();
      addr_phase(off);
      for (int i = 0; i < 5; i++) bit_w(1'($urandom));
      i2c_stop;
      wclk(H);
      chk("abort_no_wr", wr_log.size(), 0);
      chk("abort_busy", busy, 1'b0);
      exp_ptr = off;
      chk("abort_addr", reg_addr, exp_ptr);
   endtask

   // Reset in the high phase of the first (zero-valued) read data bit.
   task automatic do_reset_mid_read;
      logic a;
      addr_phase(16'h1234);
      i2c_start;
      byte_w({DEV, 1'b1}, a);
      chk("rst_rdev_ack", a, ACK);
      wclk(2); m_sda = 1'b1; wclk(H - 2); m_scl = 1'b1; wclk(4);
      chk("rst_drive_lo", sda_out, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("rst_sda_rel", sda_out, 1'b1);
      chk("rst_addr", reg_addr, 16'h0000);
      chk("rst_wdata", reg_wdata, 8'h00);
      chk("rst_strobes", {reg_wr, reg_rd}, 2'b00);
      chk("rst_busy", busy, 1'b0);
      wclk(H);
      resetn  = 1'b1;
      exp_ptr = 16'h0000;
      wclk(H);
   endtask

   task automatic run_random(input int iters);
      int          kind;
      int          n;
      logic [15:0] off;
      logic [6:0]  dev;
      for (int t = 0; t < iters; t++) begin
         kind = int'($urandom_range(0, 2));
         off  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1))
                                            : 16'($urandom);
         case (kind)
            0: begin
               n = int'($urandom_range(1, 4));
               for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
               do_write(off, n);
            end
            1: do_read(off, int'($urandom_range(1, 3)));
            default: begin
               dev = 7'($urandom);
               if (dev == DEV) dev = dev ^ 7'h01;
               do_mismatch(dev, 1'($urandom));
            end
         endcase
         wclk(H);
      end
   endtask

   initial begin
      resetn = 1'b0;
      wclk(3);
      chk("reset_sda", sda_out, 1'b1);
      chk("reset_wr", reg_wr, 1'b0);
      chk("reset_rd", reg_rd, 1'b0);
      chk("reset_addr", reg_addr, 16'h0000);
      chk("reset_wdata", reg_wdata, 8'h00);
      chk("reset_busy", busy, 1'b0);
      resetn = 1'b1;
      wclk(5);

      wbuf[0] = 8'hA5;
      do_write(16'h1234, 1);
      do_read(16'h1234, 1);
      do_mismatch(7'h25, 1'b0);

      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      do_write(16'hFFFF, 3);

      do_abort(16'h0200);
      wbuf[0] = 8'h3C;
      do_write(16'h0200, 1);

      do_reset_mid_read;
      wbuf[0] = 8'hC3; wbuf[1] = 8'h7E;
      do_write(16'h4000, 2);
      do_read(16'h4000, 2);

      run_random(12);

      chk("wr_rd_exclusive", both_hi, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
